// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback, drives datapath strobes,
// handshakes with instruction/data memories, traps on illegal opcodes or stalled memories.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [31:0]          instr,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 zero,
  output logic                 sub,
  output logic                 ULA_din2_sel,
  output logic                 RF_din_sel,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic                 load_pc,
  output logic                 reset_pc,
  output logic                 pc_next_sel,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_LW, OP_SW, OP_ADD, OP_SUB, OP_ADDI, OP_BEQ, OP_BNE, OP_ILL
  } op_t;

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t                state_q, state_d;
  logic [31:0]           ir_q, ir_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;
  logic                  reset_pc_q, reset_pc_d;

  op_t  op;
  logic alu_imm;
  logic alu_sub;
  logic is_branch;
  logic is_mem;
  logic mem_stall;

  // Only opcode/funct3/funct7 steer control; register and immediate fields belong to the datapath.
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};

  always_comb begin
    op = OP_ILL;
    case (ir_q[6:0])
      7'h03: if (ir_q[14:12] == 3'b010) op = OP_LW;
      7'h23: if (ir_q[14:12] == 3'b010) op = OP_SW;
      7'h13: if (ir_q[14:12] == 3'b000) op = OP_ADDI;
      7'h33: begin
        if (ir_q[14:12] == 3'b000) begin
          if (ir_q[31:25] == 7'h00)      op = OP_ADD;
          else if (ir_q[31:25] == 7'h20) op = OP_SUB;
        end
      end
      7'h63: begin
        if (ir_q[14:12] == 3'b000)      op = OP_BEQ;
        else if (ir_q[14:12] == 3'b001) op = OP_BNE;
      end
      default: op = OP_ILL;
    endcase
  end

  always_comb begin
    alu_imm   = (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    alu_sub   = (op == OP_SUB) || (op == OP_BEQ) || (op == OP_BNE);
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    is_mem    = (op == OP_LW) || (op == OP_SW);
  end

  // Strobes decode from the registered state; forced low while reset is held.
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    sub          = 1'b0;
    ULA_din2_sel = 1'b0;
    RF_din_sel   = 1'b0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    load_pc      = 1'b0;
    pc_next_sel  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_EXEC: begin
          sub          = alu_sub;
          ULA_din2_sel = alu_imm;
          if (is_branch) begin
            load_pc     = 1'b1;
            pc_next_sel = (op == OP_BNE) ? ~zero : zero;
          end
        end
        S_MEM: begin
          dmem_req     = 1'b1;
          ULA_din2_sel = 1'b1;
          WE_MEM       = (op == OP_SW);
          load_pc      = (op == OP_SW) && dmem_ready;
        end
        S_WB: begin
          sub          = alu_sub;
          ULA_din2_sel = alu_imm;
          RF_din_sel   = (op != OP_LW);
          WE_RF        = 1'b1;
          load_pc      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    reset_pc_d = 1'b1;
    mem_stall  = 1'b0;
    instret_d  = load_pc ? (instret_q + CNT_WIDTH'(1)) : instret_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      S_DECODE: begin
        if (op == OP_ILL) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = is_branch ? S_FETCH : (is_mem ? S_MEM : S_WB);
      S_MEM: begin
        if (dmem_ready) state_d = (op == OP_SW) ? S_FETCH : S_WB;
        else            mem_stall = 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
    // A ready arriving on the last permitted cycle clears mem_stall, so progress wins.
    if (TIMEOUT_EN && mem_stall && (wait_cnt_q == WAIT_LAST)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end
    if (state_d != state_q) wait_cnt_d = '0;
    else if (mem_stall)     wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    else                    wait_cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      instret_q  <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      reset_pc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      instret_q  <= instret_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      reset_pc_q <= reset_pc_d;
    end
  end

  assign state    = state_q;
  assign instret  = instret_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign reset_pc = reset_pc_q;

endmodule
